bmp_crop_engine: RTL and testbench
==================================

// Module: bmp_crop_engine
// PURPOSE
//  Parametrised successor of the fixed crop top. Copies a runtime-selected W x H window from a 24-bit
//  bottom-up BMP held in source byte memory into destination byte memory as a complete, valid BMP.
//  Patches the header and emits row padding. Sits between source/dest RAMs; host pulses start, polls done.
// PARAMETERS
//  ADDR_W     16  byte-address width of both memories
//  DIM_W      12  width of all image dimension/coordinate ports
//  BPP_BYTES  3   bytes per pixel (3 = 24-bit BGR)
//  HDR_BYTES  54  BMP header length (file + info header)
// PORTS
//  CLOCK_50  in   1       clock; all logic on rising edge
//  reset     in   1       synchronous, active-high reset
//  start     in   1       begin crop; sampled only in IDLE
//  src_w     in   DIM_W   source width, pixels
//  src_h     in   DIM_W   source height, pixels
//  crop_x    in   DIM_W   window left column (0 = leftmost)
//  crop_y    in   DIM_W   window top row (0 = top of displayed image)
//  crop_w    in   DIM_W   window width, pixels
//  crop_h    in   DIM_W   window height, pixels
//  rd_addr   out  ADDR_W  source byte address
//  rd_data   in   8       source byte; valid exactly 1 cycle after rd_addr
//  wr_en     out  1       destination write strobe
//  wr_addr   out  ADDR_W  destination byte address
//  wr_data   out  8       destination byte
//  busy      out  1       high from start acceptance until done
//  done      out  1       level; high after last write until next accepted start or reset
//  err       out  1       1-cycle pulse on rejected parameters
// BEHAVIOUR
//  Reset: state IDLE; rd_addr, wr_addr, wr_data, wr_en, busy, done, err all 0. Reset wins over start.
//  Reset in any state aborts: wr_en is 0 the next cycle. No partial-state carry-over.
//  Latching: dimension inputs are registered when start is accepted, and may change afterwards.
//  Derived values:
//    S_STR = ceil(src_w*BPP_BYTES/4)*4
//    O_STR = ceil(crop_w*BPP_BYTES/4)*4
//    IMG   = O_STR*crop_h
//    TOTAL = HDR_BYTES+IMG
//  States: IDLE -> CHECK -> HDR -> ROWS <-> PAD -> FLUSH -> DONE.
//  IDLE: start=1 -> CHECK and busy=1; done clears. start while busy is ignored.
//  CHECK (1 cycle): reject if any of the following holds:
//    - crop_w=0 or crop_h=0
//    - crop_x+crop_w > src_w or crop_y+crop_h > src_h (compare at DIM_W+1 bits)
//    - TOTAL > 2^ADDR_W
//  Reject: err=1 for one cycle, busy=0, return to IDLE with no writes and done stays 0.
//  Accept: go to HDR.
//  HDR: reads source bytes 0..HDR_BYTES-1 and writes them to the same dest addresses, with these
//  fields replaced by little-endian 32-bit values:
//    - bytes 2-5   = TOTAL
//    - bytes 18-21 = crop_w
//    - bytes 22-25 = crop_h
//    - bytes 34-37 = IMG
//  All other header bytes are copied verbatim.
//  ROWS: output row r runs 0..crop_h-1, bottom-up. Its source row is sr = src_h-crop_y-crop_h+r.
//    Source address = HDR_BYTES + sr*S_STR + crop_x*BPP_BYTES + b, for b in 0..crop_w*BPP_BYTES-1.
//    Row bases are built by accumulating S_STR/O_STR; no multiplier in the per-byte path.
//  PAD: writes O_STR-crop_w*BPP_BYTES zero bytes (0..3) after each row, with no source reads.
//    Zero pad bytes -> skip PAD.
//  Pipeline: rd_addr issued in cycle n; matching wr_en/wr_addr/wr_data appear in cycle n+1.
//    Pad writes are slotted in the same stream.
//  Throughput: one dest byte per cycle, no bubbles. wr_addr runs 0..TOTAL-1 strictly incrementing.
//  Latency: start accepted at edge k -> first wr_en at cycle k+3. wr_en is high exactly TOTAL
//  consecutive cycles. done=1 and busy=0 on the cycle after the last write (FLUSH -> DONE).
//  DONE: done held. start=1 -> restart directly (CHECK), done clears.
// TESTING
//  1. 64x64 src, crop (0,0,52,37) -> 5826 writes; bytes 2-5 = C2 16 00 00; 18-21 = 34 00 00 00;
//     22-25 = 25 00 00 00; 34-37 = 8C 16 00 00.
//  2. Crop (5,7,1,2) of 64x64 -> O_STR 4; per row 3 copied bytes then one 00 at offset 3; TOTAL 62.
//  3. crop_x=60, crop_w=5 on src_w=64 -> err high 1 cycle, zero wr_en, busy 0, done 0.
//  4. Reset asserted mid-ROWS -> wr_en=0 and busy=0 next cycle; rerun gives output identical to a
//     clean run.
//  5. start pulsed while busy -> ignored; write count and data unchanged.
//  6. Full-frame crop (0,0,src_w,src_h) with src_w=64 -> dest equals source byte-for-byte over
//     TOTAL bytes; done rises TOTAL+3 cycles after start.

Source files
------------

// File: rtl/bmp_crop_engine_if.sv
// rtl/bmp_crop_engine_if.sv - host control, source-read and dest-write signals of the BMP crop engine
interface bmp_crop_engine_if #(
   parameter int ADDR_W = 16,
   parameter int DIM_W  = 12
);
   logic              start;
   logic [DIM_W-1:0]  src_w;
   logic [DIM_W-1:0]  src_h;
   logic [DIM_W-1:0]  crop_x;
   logic [DIM_W-1:0]  crop_y;
   logic [DIM_W-1:0]  crop_w;
   logic [DIM_W-1:0]  crop_h;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              busy;
   logic              done;
   logic              err;

   // host plus both RAMs, seen from outside the engine
   modport master (
      output start, src_w, src_h, crop_x, crop_y, crop_w, crop_h, rd_data,
      input  rd_addr, wr_en, wr_addr, wr_data, busy, done, err
   );

   // the crop engine itself
   modport slave (
      input  start, src_w, src_h, crop_x, crop_y, crop_w, crop_h, rd_data,
      output rd_addr, wr_en, wr_addr, wr_data, busy, done, err
   );
endinterface

// File: rtl/bmp_crop_engine.sv
// rtl/bmp_crop_engine.sv - copies a W x H window of a 24-bit bottom-up BMP into a new, complete BMP
module bmp_crop_engine #(
   parameter int ADDR_W    = 16,
   parameter int DIM_W     = 12,
   parameter int BPP_BYTES = 3,
   parameter int HDR_BYTES = 54
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   bmp_crop_engine_if.slave bus
);
   localparam int CW  = 32;                       // width of derived size arithmetic
   localparam int HW  = $clog2(HDR_BYTES + 1);    // header byte index
   localparam int RBW = DIM_W + 3;                // bytes-in-row counter

   typedef enum logic [2:0] {
      S_IDLE, S_CHECK, S_HDR, S_ROWS, S_PAD, S_FLUSH, S_DONE
   } state_t;

   state_t state_q, state_d;

   // parameters captured when start is accepted
   logic [DIM_W-1:0]  src_w_q, src_h_q, crop_x_q, crop_y_q, crop_w_q, crop_h_q;

   // derived sizes, valid from the CHECK cycle onwards
   logic [CW-1:0]     row_bytes_c, s_str_c, o_str_c, img_c, total_c;
   logic [ADDR_W-1:0] base0_c;
   logic              reject_c;
   logic [CW-1:0]     img_q, total_q;
   logic [ADDR_W-1:0] s_str_q;
   logic [RBW-1:0]    row_last_q;
   logic [1:0]        pad_bytes_q;

   // walk state
   logic [HW-1:0]     hdr_idx_q;
   logic [CW-1:0]     hidx_c;
   logic [RBW-1:0]    byte_cnt_q;
   logic [DIM_W-1:0]  row_cnt_q;
   logic [1:0]        pad_cnt_q;
   logic [ADDR_W-1:0] row_base_q, rd_ptr_q, out_ptr_q;
   logic              hdr_last_c, row_end_c, last_row_c, pad_end_c, accept_start_c;

   // write stage: registered alongside the read issued one cycle earlier
   logic              wr_en_q, wr_src_q, err_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_byte_q;

   // output-decode results
   logic              issue_c, issue_src_c, busy_c, done_c;
   logic [7:0]        issue_byte_c;
   logic              patch_hit_c;
   logic [CW-1:0]     patch_field_c;

   function automatic logic [7:0] le_byte(input logic [CW-1:0] v, input logic [1:0] sel);
      case (sel)
         2'd0:    return v[7:0];
         2'd1:    return v[15:8];
         2'd2:    return v[23:16];
         default: return v[31:24];
      endcase
   endfunction

   // sizes and the acceptance test, all from the latched parameters
   always_comb begin
      row_bytes_c = CW'(crop_w_q) * CW'(BPP_BYTES);
      o_str_c     = (row_bytes_c + CW'(3)) & ~CW'(3);
      s_str_c     = ((CW'(src_w_q) * CW'(BPP_BYTES)) + CW'(3)) & ~CW'(3);
      img_c       = o_str_c * CW'(crop_h_q);
      total_c     = CW'(HDR_BYTES) + img_c;
      // bottom-up storage: output row 0 is source row src_h-crop_y-crop_h
      base0_c     = ADDR_W'(CW'(HDR_BYTES)
                    + (CW'(src_h_q) - CW'(crop_y_q) - CW'(crop_h_q)) * s_str_c
                    + CW'(crop_x_q) * CW'(BPP_BYTES));
      reject_c    = (crop_w_q == '0) || (crop_h_q == '0)
                    || (({1'b0, crop_x_q} + {1'b0, crop_w_q}) > {1'b0, src_w_q})
                    || (({1'b0, crop_y_q} + {1'b0, crop_h_q}) > {1'b0, src_h_q})
                    || (total_c > (CW'(1) << ADDR_W));
   end

   // loop-termination flags
   always_comb begin
      hidx_c         = CW'(hdr_idx_q);
      hdr_last_c     = (hidx_c == CW'(HDR_BYTES - 1));
      row_end_c      = (byte_cnt_q == row_last_q);
      last_row_c     = (row_cnt_q == crop_h_q - 1'b1);
      pad_end_c      = (pad_cnt_q == pad_bytes_q - 2'd1);
      accept_start_c = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
   end

   // state register
   always_ff @(posedge CLOCK_50) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_CHECK;
         S_CHECK: state_d = reject_c ? S_IDLE : S_HDR;
         S_HDR:   if (hdr_last_c) state_d = S_ROWS;
         S_ROWS: begin
            if (row_end_c) begin
               if (pad_bytes_q != 2'd0) state_d = S_PAD;
               else if (last_row_c)     state_d = S_FLUSH;
               else                     state_d = S_ROWS;
            end
         end
         S_PAD:   if (pad_end_c) state_d = last_row_c ? S_FLUSH : S_ROWS;
         S_FLUSH: state_d = S_DONE;
         S_DONE:  if (bus.start) state_d = S_CHECK;
         default: state_d = S_IDLE;
      endcase
   end

   // output decode: what the byte issued this cycle will become, plus status
   always_comb begin
      issue_c       = 1'b0;
      issue_src_c   = 1'b0;
      issue_byte_c  = 8'h00;
      patch_hit_c   = 1'b0;
      patch_field_c = '0;
      busy_c        = (state_q != S_IDLE) && (state_q != S_DONE);
      done_c        = (state_q == S_DONE);
      case (state_q)
         S_HDR: begin
            issue_c = 1'b1;
            if (hidx_c >= 2 && hidx_c <= 5) begin
               patch_hit_c = 1'b1; patch_field_c = total_q;
            end else if (hidx_c >= 18 && hidx_c <= 21) begin
               patch_hit_c = 1'b1; patch_field_c = CW'(crop_w_q);
            end else if (hidx_c >= 22 && hidx_c <= 25) begin
               patch_hit_c = 1'b1; patch_field_c = CW'(crop_h_q);
            end else if (hidx_c >= 34 && hidx_c <= 37) begin
               patch_hit_c = 1'b1; patch_field_c = img_q;
            end
            issue_src_c = !patch_hit_c;
            // every patched field starts at an offset that is 2 mod 4
            if (patch_hit_c) issue_byte_c = le_byte(patch_field_c, hdr_idx_q[1:0] - 2'd2);
         end
         S_ROWS:  begin issue_c = 1'b1; issue_src_c = 1'b1; end
         S_PAD:   issue_c = 1'b1;
         default: issue_c = 1'b0;
      endcase
   end

   // datapath: parameter capture, address walk and the write stage
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         src_w_q <= '0; src_h_q <= '0; crop_x_q <= '0;
         crop_y_q <= '0; crop_w_q <= '0; crop_h_q <= '0;
         img_q <= '0; total_q <= '0; s_str_q <= '0; row_last_q <= '0; pad_bytes_q <= '0;
         hdr_idx_q <= '0; byte_cnt_q <= '0; row_cnt_q <= '0; pad_cnt_q <= '0;
         row_base_q <= '0; rd_ptr_q <= '0; out_ptr_q <= '0;
         wr_en_q <= 1'b0; wr_src_q <= 1'b0; wr_addr_q <= '0; wr_byte_q <= '0; err_q <= 1'b0;
      end else begin
         err_q   <= 1'b0;
         wr_en_q <= issue_c;
         if (issue_c) begin
            wr_addr_q <= out_ptr_q;
            out_ptr_q <= out_ptr_q + 1'b1;
            wr_src_q  <= issue_src_c;
            wr_byte_q <= issue_byte_c;
         end
         if (accept_start_c) begin
            src_w_q  <= bus.src_w;  src_h_q  <= bus.src_h;
            crop_x_q <= bus.crop_x; crop_y_q <= bus.crop_y;
            crop_w_q <= bus.crop_w; crop_h_q <= bus.crop_h;
         end
         case (state_q)
            S_CHECK: begin
               err_q       <= reject_c;
               img_q       <= img_c;
               total_q     <= total_c;
               s_str_q     <= ADDR_W'(s_str_c);
               row_last_q  <= RBW'(row_bytes_c - CW'(1));
               pad_bytes_q <= 2'(o_str_c - row_bytes_c);
               row_base_q  <= base0_c;
               rd_ptr_q    <= '0;
               out_ptr_q   <= '0;
               hdr_idx_q   <= '0;
               byte_cnt_q  <= '0;
               row_cnt_q   <= '0;
               pad_cnt_q   <= '0;
            end
            S_HDR: begin
               hdr_idx_q <= hdr_idx_q + 1'b1;
               rd_ptr_q  <= hdr_last_c ? row_base_q : rd_ptr_q + 1'b1;
            end
            S_ROWS: begin
               if (row_end_c) begin
                  byte_cnt_q <= '0;
                  row_base_q <= row_base_q + s_str_q;
                  rd_ptr_q   <= row_base_q + s_str_q;
                  if (pad_bytes_q == 2'd0) row_cnt_q <= row_cnt_q + 1'b1;
               end else begin
                  byte_cnt_q <= byte_cnt_q + 1'b1;
                  rd_ptr_q   <= rd_ptr_q + 1'b1;
               end
            end
            S_PAD: begin
               if (pad_end_c) begin
                  pad_cnt_q <= '0;
                  row_cnt_q <= row_cnt_q + 1'b1;
               end else begin
                  pad_cnt_q <= pad_cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rd_addr = rd_ptr_q;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = !wr_en_q ? 8'h00 : (wr_src_q ? bus.rd_data : wr_byte_q);
   assign bus.busy    = busy_c;
   assign bus.done    = done_c;
   assign bus.err     = err_q;
endmodule

// File: tb/tb_bmp_crop_engine.sv
// tb/tb_bmp_crop_engine.sv - directed vector bench for bmp_crop_engine
module tb_bmp_crop_engine;
   localparam int ADDR_W = 16;
   localparam int DIM_W  = 12;
   localparam int HDR    = 54;

   typedef struct {
      int sw; int sh; int x; int y; int w; int h;
      int exp_err; int exp_total; int poke;
   } vec_t;

   logic CLOCK_50 = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] src_mem [0:65535];
   logic [7:0] dst_mem [0:65535];
   vec_t       vecs [10];

   always #5 CLOCK_50 = ~CLOCK_50;

   bmp_crop_engine_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

   bmp_crop_engine #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .BPP_BYTES(3), .HDR_BYTES(HDR)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (bus)
   );

   // source RAM: data valid one cycle after the address
   always @(posedge CLOCK_50) bus.rd_data <= src_mem[bus.rd_addr];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_byte(input int a, input vec_t v);
      int rb, ostr, sstr, img, tot, off, r, c, sr, f;
      rb   = v.w * 3;
      ostr = ((rb + 3) / 4) * 4;
      sstr = ((v.sw * 3 + 3) / 4) * 4;
      img  = ostr * v.h;
      tot  = HDR + img;
      if (a < HDR) begin
         f = -1;
         if (a >= 2 && a <= 5)        begin f = tot;  off = a - 2;  end
         else if (a >= 18 && a <= 21) begin f = v.w;  off = a - 18; end
         else if (a >= 22 && a <= 25) begin f = v.h;  off = a - 22; end
         else if (a >= 34 && a <= 37) begin f = img;  off = a - 34; end
         if (f < 0) return src_mem[a];
         return 8'((f >> (8 * off)) & 255);
      end
      off = a - HDR;
      r   = off / ostr;
      c   = off % ostr;
      if (c >= rb) return 8'h00;
      sr  = v.sh - v.y - v.h + r;
      return src_mem[(HDR + sr * sstr + v.x * 3 + c) & 16'hFFFF];
   endfunction

   task automatic set_dims(input int sw, input int sh, input int x, input int y,
                           input int w, input int h);
      bus.src_w  = DIM_W'(sw); bus.src_h  = DIM_W'(sh);
      bus.crop_x = DIM_W'(x);  bus.crop_y = DIM_W'(y);
      bus.crop_w = DIM_W'(w);  bus.crop_h = DIM_W'(h);
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int cyc, wr_cnt, err_cnt, first_wr, done_cyc, addr_bad, mism, exp_addr, limit;
      logic [7:0] e;
      cyc = 0; wr_cnt = 0; err_cnt = 0; first_wr = -1; done_cyc = -1;
      addr_bad = 0; mism = 0; exp_addr = 0;
      for (int a = 0; a < 65536; a++) dst_mem[a] = 8'hA5;
      limit = (v.exp_err != 0) ? 10 : v.exp_total + 20;
      @(negedge CLOCK_50);
      set_dims(v.sw, v.sh, v.x, v.y, v.w, v.h);
      bus.start = 1'b1;
      while (cyc < limit && done_cyc < 0) begin
         @(negedge CLOCK_50);
         cyc++;
         if (cyc == 1) begin
            bus.start = 1'b0;
            set_dims(64, 64, 1, 1, 9, 9);
         end
         if (v.poke != 0 && cyc == v.poke)     bus.start = 1'b1;
         if (v.poke != 0 && cyc == v.poke + 1) bus.start = 1'b0;
         if (bus.wr_en) begin
            if (first_wr < 0) first_wr = cyc;
            if (int'(bus.wr_addr) != exp_addr) addr_bad++;
            exp_addr++;
            wr_cnt++;
            dst_mem[bus.wr_addr] = bus.wr_data;
         end
         if (bus.err) err_cnt++;
         if (bus.done) done_cyc = cyc;
      end
      check($sformatf("v%0d_err_pulses", id), err_cnt, v.exp_err);
      check($sformatf("v%0d_writes", id), wr_cnt, (v.exp_err != 0) ? 0 : v.exp_total);
      check($sformatf("v%0d_done", id), int'(bus.done), (v.exp_err != 0) ? 0 : 1);
      check($sformatf("v%0d_busy_end", id), int'(bus.busy), 0);
      if (v.exp_err == 0) begin
         check($sformatf("v%0d_first_wr_cycle", id), first_wr, 3);
         check($sformatf("v%0d_done_cycle", id), done_cyc, v.exp_total + 3);
         check($sformatf("v%0d_addr_order_bad", id), addr_bad, 0);
         for (int a = 0; a < v.exp_total; a++) begin
            e = exp_byte(a, v);
            if (dst_mem[a] !== e) begin
               if (mism == 0)
                  $display("v%0d first data difference at %0d: got %02h want %02h",
                           id, a, dst_mem[a], e);
               mism++;
            end
         end
         check($sformatf("v%0d_data_mismatches", id), mism, 0);
      end
   endtask

   initial begin
      int diff;
      for (int a = 0; a < 65536; a++)
         src_mem[a] = 8'(((a * 37) + ((a >> 8) * 11) + (a >> 3) + 5) & 255);
      // consistent 64x64 header so a full-frame crop reproduces the source exactly
      src_mem[0] = 8'h42; src_mem[1] = 8'h4D;
      src_mem[2] = 8'h36; src_mem[3] = 8'h30; src_mem[4] = 8'h00; src_mem[5] = 8'h00;
      src_mem[18] = 8'h40; src_mem[19] = 8'h00; src_mem[20] = 8'h00; src_mem[21] = 8'h00;
      src_mem[22] = 8'h40; src_mem[23] = 8'h00; src_mem[24] = 8'h00; src_mem[25] = 8'h00;
      src_mem[34] = 8'h00; src_mem[35] = 8'h30; src_mem[36] = 8'h00; src_mem[37] = 8'h00;

      //            sw    sh    x   y   w     h   err total  poke
      vecs[0] = '{  64,   64,   0,  0,  52,   37, 0,  5826,  0 };
      vecs[1] = '{  64,   64,   5,  7,  1,    2,  0,  62,    0 };
      vecs[2] = '{  64,   64,   60, 0,  5,    1,  1,  0,     0 };
      vecs[3] = '{  64,   64,   0,  0,  64,   64, 0,  12342, 100 };
      vecs[4] = '{  64,   64,   3,  10, 7,    3,  0,  126,   20 };
      vecs[5] = '{  64,   64,   62, 62, 2,    2,  0,  70,    0 };
      vecs[6] = '{  64,   64,   0,  5,  0,    5,  1,  0,     0 };
      vecs[7] = '{  64,   64,   10, 60, 4,    5,  1,  0,     0 };
      vecs[8] = '{  4095, 4095, 0,  0,  4095, 16, 1,  0,     0 };
      vecs[9] = '{  64,   64,   0,  63, 64,   1,  0,  246,   0 };

      // reset with start held: reset wins, everything cleared
      reset = 1'b1;
      bus.start = 1'b1;
      set_dims(64, 64, 0, 0, 4, 4);
      repeat (3) @(negedge CLOCK_50);
      check("rst_rd_addr", int'(bus.rd_addr), 0);
      check("rst_wr_addr", int'(bus.wr_addr), 0);
      check("rst_wr_data", int'(bus.wr_data), 0);
      check("rst_wr_en", int'(bus.wr_en), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_err", int'(bus.err), 0);
      bus.start = 1'b0;
      reset = 1'b0;
      @(negedge CLOCK_50);

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i], i);
         if (i == 0) begin
            check("hdr_total", int'({dst_mem[5], dst_mem[4], dst_mem[3], dst_mem[2]}), 32'h000016C2);
            check("hdr_width", int'({dst_mem[21], dst_mem[20], dst_mem[19], dst_mem[18]}), 32'h00000034);
            check("hdr_height", int'({dst_mem[25], dst_mem[24], dst_mem[23], dst_mem[22]}), 32'h00000025);
            check("hdr_img", int'({dst_mem[37], dst_mem[36], dst_mem[35], dst_mem[34]}), 32'h0000168C);
         end
         if (i == 1) begin
            check("c1_row0_byte0", int'(dst_mem[54]), int'(src_mem[10629]));
            check("c1_row0_pad", int'(dst_mem[57]), 0);
            check("c1_row1_byte0", int'(dst_mem[58]), int'(src_mem[10821]));
            check("c1_row1_pad", int'(dst_mem[61]), 0);
         end
         if (i == 3) begin
            diff = 0;
            for (int a = 0; a < 12342; a++) if (dst_mem[a] !== src_mem[a]) diff++;
            check("full_frame_vs_source", diff, 0);
         end
      end

      // reset in the middle of the row stream, then a clean rerun
      @(negedge CLOCK_50);
      set_dims(64, 64, 3, 10, 7, 3);
      bus.start = 1'b1;
      @(negedge CLOCK_50);
      bus.start = 1'b0;
      repeat (69) @(negedge CLOCK_50);
      check("mid_rows_busy", int'(bus.busy), 1);
      check("mid_rows_wr_en", int'(bus.wr_en), 1);
      reset = 1'b1;
      @(negedge CLOCK_50);
      check("abort_wr_en", int'(bus.wr_en), 0);
      check("abort_busy", int'(bus.busy), 0);
      check("abort_done", int'(bus.done), 0);
      reset = 1'b0;
      run_vec(vecs[4], 40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
